integrator_cascade: RTL and testbench
=====================================

# integrator_cascade

Parametrised cascade of ORDER signed accumulators. It generalises the single-stage integrator to an N-th order chain with a valid-qualified sample stream, synchronous clear, overflow detection and optional saturation. It sits in the DSM datapath as the loop-filter and CIC integrator section, ahead of the quantiser or comb/decimator.

## Interface
- ORDER, default 2: number of cascaded integrator stages, legal range 1..5.
- IN_WIDTH, default 4: signed input sample width.
- ACC_WIDTH, default IN_WIDTH + 2*ORDER: signed width of every stage accumulator. Must be ≥ IN_WIDTH.

Ports:
- i_clk  input  1  clock. One clock; reset is synchronous and active-high.
- i_rst  input  1  synchronous active-high reset.
- i_valid  input  1  input sample qualifier.
- i_data  input  IN_WIDTH  signed input sample.
- i_clr  input  1  synchronous clear of all accumulators, valid pipeline and overflow flag.
- o_valid  output  1  output sample qualifier.
- o_data  output  ACC_WIDTH  signed output of last stage.
- o_ovf  output  1  sticky overflow flag, set if any stage overflowed.

## Operation
- Stage k has accumulator acc[k] and valid bit v[k], for k = 1..ORDER. Let v[0] = i_valid and src[1] = i_data sign-extended to ACC_WIDTH.
- For stage k ≥ 2, src[k] = acc[k-1], the registered output of the previous stage. The cascade is therefore pipelined with no combinational chain.
- On each edge, for every k: if v[k-1] is high, then acc[k] <= acc[k] + src[k] and v[k] <= 1. Otherwise acc[k] holds and v[k] <= 0.
- Outputs: o_data = acc[ORDER], o_valid = v[ORDER].
- Arithmetic is two's complement at ACC_WIDTH. Overflow means the operands have the same sign and the sum's sign differs from it.
- Any stage overflow during an update sets o_ovf. o_ovf stays set until i_rst or i_clr.
- i_rst and i_clr have identical effect. All acc[k] <= 0, all v[k] <= 0, o_ovf <= 0.
- If i_clr and i_valid are high in the same cycle, clear wins and the sample is dropped.
- If i_rst or i_clr is asserted mid-stream, in-flight samples are discarded and no o_valid follows for them.
- ORDER = 1 with i_valid tied high behaves as a plain accumulator.

## Timing
- Reset values: o_data = 0, o_valid = 0, o_ovf = 0.
- Latency: a sample presented with i_valid at edge n first affects o_data at edge n+ORDER-1. o_valid is asserted after edge n+ORDER-1 and visible in the cycle after it.
- Throughput is one sample per cycle. Gaps in i_valid propagate as gaps in o_valid, delayed by ORDER.
- o_ovf is updated at the same edge as the overflowing accumulator.
- There is no backpressure; the downstream block must accept every o_valid beat.

## Configuration
- INTEGRATOR_CASCADE_SAT_EN defined: an overflowing stage update clamps to 2^(ACC_WIDTH-1)-1 on positive overflow, or -2^(ACC_WIDTH-1) on negative overflow. o_ovf is still set.
- Not defined: overflow wraps modulo 2^ACC_WIDTH, as required for CIC operation. o_ovf is still set.

## Structure
- integrator_pkg holds:
  - the ACC_MAX and ACC_MIN constant functions of width;
  - the signed overflow-detect function;
  - the saturating-add function.
- Sub-module integrator_stage: one accumulator with valid in/out, clear, overflow output and the macro-dependent saturate/wrap logic.
- The top level instantiates ORDER stages in a generate loop and ORs their overflow outputs into the sticky flag.

## Test plan
- Reset: hold i_rst 3 cycles with i_valid=1, i_data=5 -> o_data=0, o_valid=0, o_ovf=0 throughout and one cycle after release.
- Step, ORDER=2, IN_WIDTH=4, ACC_WIDTH=8, i_data=1 every cycle from edge 0 -> o_data=1, 3, 6, 10, 15 after edges 1..5; o_valid high from after edge 1.
- Gapped stream, ORDER=2: i_valid pattern 1,0,1 with i_data=2 -> o_valid pattern 1,0,1 delayed by 2 cycles; o_data holds during the gap.
- Overflow, ORDER=1, IN_WIDTH=4, ACC_WIDTH=6, i_data=7 repeated -> 7, 14, 21, 28, then:
  - without macro: -29;
  - with macro: 31, 31, ...;
  - o_ovf=1 from the fifth update in both builds.
- Clear collision: mid-stream i_clr=1 with i_valid=1, i_data=3 -> all outputs 0 next cycle, o_ovf cleared, sample dropped; no stale o_valid appears ORDER cycles later.
- Negative input, ORDER=3, ACC_WIDTH=10, i_data=-1 constant -> o_data = -1, -4, -10 after the first three o_valid beats.

Source files
------------

// File: rtl/integrator_pkg.sv
// integrator_pkg
// Shared helpers for the integrator cascade:
//   acc_max / acc_min : most positive / most negative two's complement value
//                       for a given width, returned sign-extended to MAX_W bits
//   add_ovf           : signed-add overflow from the operand and sum sign bits
//   sat_add           : add two sign-extended values and clamp to a width
// Used by integrator_stage (INTEGRATOR_CASCADE_SAT_EN selects the saturating path).
package integrator_pkg;

  localparam int MAX_W = 64;

  typedef logic signed [MAX_W-1:0] wide_t;

  function automatic wide_t acc_max(input int width);
    return wide_t'((64'sd1 <<< (width - 1)) - 64'sd1);
  endfunction

  function automatic wide_t acc_min(input int width);
    return wide_t'(-(64'sd1 <<< (width - 1)));
  endfunction

  function automatic logic add_ovf(input logic a_sign, input logic b_sign,
                                   input logic sum_sign);
    return (a_sign == b_sign) && (sum_sign != a_sign);
  endfunction

  // Operands arrive sign-extended to MAX_W, so the wide sum cannot itself
  // overflow for any accumulator width this block supports.
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int width);
    wide_t sum;
    sum = a + b;
    if (sum > acc_max(width)) return acc_max(width);
    if (sum < acc_min(width)) return acc_min(width);
    return sum;
  endfunction

endpackage

// File: rtl/integrator_stage.sv
// integrator_stage
// One signed accumulator of the cascade with a valid qualifier.
// Build option: INTEGRATOR_CASCADE_SAT_EN defined -> overflowing updates clamp
// to the accumulator range; undefined -> updates wrap modulo 2^ACC_WIDTH.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_clr          synchronous clear (same effect as reset)
//   i_valid        source value is valid this cycle
//   i_src          signed addend (previous stage output or input sample)
//   o_acc          registered accumulator
//   o_valid        registered valid, one cycle behind i_valid
//   o_ovf          combinational: this cycle's update overflows
module integrator_stage
  import integrator_pkg::*;
#(
  parameter int ACC_WIDTH = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clr,
  input  logic                        i_valid,
  input  logic signed [ACC_WIDTH-1:0] i_src,
  output logic signed [ACC_WIDTH-1:0] o_acc,
  output logic                        o_valid,
  output logic                        o_ovf
);

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] sum_wrap;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic                        valid_q;
  logic                        ovf;
  logic                        flush;

  assign flush    = i_rst | i_clr;
  assign sum_wrap = acc_q + i_src;
  assign ovf      = add_ovf(acc_q[ACC_WIDTH-1], i_src[ACC_WIDTH-1], sum_wrap[ACC_WIDTH-1]);

`ifdef INTEGRATOR_CASCADE_SAT_EN
  assign acc_d = ACC_WIDTH'(sat_add(wide_t'(acc_q), wide_t'(i_src), ACC_WIDTH));
`else
  assign acc_d = sum_wrap;
`endif

  always_ff @(posedge i_clk) begin
    if (flush) begin
      acc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= i_valid;
      if (i_valid) acc_q <= acc_d;
    end
  end

  assign o_acc   = acc_q;
  assign o_valid = valid_q;
  // Only a real update can overflow; a held accumulator never does.
  assign o_ovf   = i_valid & ovf;

endmodule

// File: rtl/integrator_cascade.sv
// integrator_cascade
// ORDER cascaded signed integrators with a valid-qualified sample stream,
// synchronous clear and a sticky overflow flag. Each stage adds the registered
// output of the previous stage, so there is no combinational adder chain.
// Build option: INTEGRATOR_CASCADE_SAT_EN (saturate instead of wrap).
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_valid        input sample qualifier
//   i_data         signed input sample (IN_WIDTH)
//   i_clr          synchronous clear of accumulators, valids and o_ovf
//   o_valid        output sample qualifier
//   o_data         last stage accumulator (ACC_WIDTH)
//   o_ovf          sticky: some stage overflowed since the last reset/clear
module integrator_cascade
  import integrator_pkg::*;
#(
  parameter int ORDER     = 2,
  parameter int IN_WIDTH  = 4,
  parameter int ACC_WIDTH = IN_WIDTH + 2 * ORDER
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  input  logic signed [IN_WIDTH-1:0]  i_data,
  input  logic                        i_clr,
  output logic                        o_valid,
  output logic signed [ACC_WIDTH-1:0] o_data,
  output logic                        o_ovf
);

  // acc[0]/vld[0] are the sign-extended input and its qualifier; acc[k]/vld[k]
  // are the registered outputs of stage k.
  logic signed [ACC_WIDTH-1:0] acc [0:ORDER];
  logic [ORDER:0]              vld;
  logic [ORDER-1:0]            stage_ovf;
  logic                        ovf_q;

  assign acc[0] = ACC_WIDTH'(i_data);
  assign vld[0] = i_valid;

  for (genvar k = 1; k <= ORDER; k++) begin : g_stage
    integrator_stage #(
      .ACC_WIDTH (ACC_WIDTH)
    ) u_stage (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (i_clr),
      .i_valid (vld[k-1]),
      .i_src   (acc[k-1]),
      .o_acc   (acc[k]),
      .o_valid (vld[k]),
      .o_ovf   (stage_ovf[k-1])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) ovf_q <= 1'b0;
    else if (|stage_ovf) ovf_q <= 1'b1;
  end

  assign o_data  = acc[ORDER];
  assign o_valid = vld[ORDER];
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_integrator_cascade.sv
// tb_integrator_cascade
// Three cascades (ORDER/ACC_WIDTH = 2/8, 1/6, 3/10, IN_WIDTH 4) share one
// stimulus stream. The reference model works on the sequence of accepted
// samples: after sample j, stage m holds stage m-1's value after sample j plus
// its own previous value. Each sample pushes its expected output and output
// cycle into a per-DUT queue; a negedge monitor pops and compares.
module tb_integrator_cascade;

  localparam int NCYC = 4096;
  localparam int NEP  = 512;
  localparam int BIG  = 1 << 30;

  typedef struct {
    int     out_c;
    int     t;
    longint data;
  } exp_t;

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b1;
  logic               i_clr = 1'b0;
  logic               i_valid = 1'b0;
  logic signed [3:0]  i_data = '0;

  logic              v0, v1, v2, f0, f1, f2;
  logic signed [7:0] d0;
  logic signed [5:0] d1;
  logic signed [9:0] d2;

  integrator_cascade #(.ORDER(2), .IN_WIDTH(4), .ACC_WIDTH(8)) u_dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .i_clr(i_clr), .o_valid(v0), .o_data(d0), .o_ovf(f0));
  integrator_cascade #(.ORDER(1), .IN_WIDTH(4), .ACC_WIDTH(6)) u_dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .i_clr(i_clr), .o_valid(v1), .o_data(d1), .o_ovf(f1));
  integrator_cascade #(.ORDER(3), .IN_WIDTH(4), .ACC_WIDTH(10)) u_dut2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .i_clr(i_clr), .o_valid(v2), .o_data(d2), .o_ovf(f2));

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int     ord_c [3] = '{2, 1, 3};
  int     wid_c [3] = '{8, 6, 10};
  longint dut_d [3];
  logic   dut_v [3];
  logic   dut_f [3];

  always_comb begin
    dut_d[0] = longint'(d0); dut_d[1] = longint'(d1); dut_d[2] = longint'(d2);
    dut_v[0] = v0; dut_v[1] = v1; dut_v[2] = v2;
    dut_f[0] = f0; dut_f[1] = f1; dut_f[2] = f2;
  end

  // model state
  exp_t   sb_q [3][$];
  longint s [3][1:5];
  longint last_d [3];
  int     first_ev [3][NEP];
  int     ep_at [NCYC];
  bit     clr_at [NCYC];
  int     epoch = 0;
  bit     done = 1'b0;
  int     n_checks = 0;
  int     n_errors = 0;

  function automatic longint wrap(input longint v, input int w);
    longint span, r;
    span = longint'(1) << w;
    r = v & (span - 1);
    if (r >= span / 2) r = r - span;
    return r;
  endfunction

  function automatic longint clamp(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic chk(input string name, input int inst, input int c,
                     input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, inst, c, act, exp);
    end
  endtask

  // Sample x accepted at edge t by every cascade.
  task automatic model_sample(input int i, input longint x, input int t);
    longint src, sum;
    exp_t   e;
    src = x;
    for (int m = 1; m <= ord_c[i]; m++) begin
      sum = s[i][m] + src;
      if (sum != wrap(sum, wid_c[i]) && (t + m - 1) < first_ev[i][epoch])
        first_ev[i][epoch] = t + m - 1;
`ifdef INTEGRATOR_CASCADE_SAT_EN
      s[i][m] = clamp(sum, wid_c[i]);
`else
      s[i][m] = wrap(sum, wid_c[i]);
`endif
      src = s[i][m];
    end
    e.out_c = t + ord_c[i] - 1;
    e.t     = t;
    e.data  = s[i][ord_c[i]];
    sb_q[i].push_back(e);
  endtask

  task automatic step(input bit rst, input bit clr, input bit vld, input int d);
    int e;
    e = cyc + 1;
    i_rst   = rst;
    i_clr   = clr;
    i_valid = vld;
    i_data  = 4'(d);
    if (e < NCYC) begin
      if (rst || clr) begin
        if (epoch < NEP - 1) epoch++;
        clr_at[e] = 1'b1;
        for (int i = 0; i < 3; i++) begin
          for (int m = 1; m <= 5; m++) s[i][m] = 0;
          first_ev[i][epoch] = BIG;
        end
      end else begin
        clr_at[e] = 1'b0;
        if (vld) for (int i = 0; i < 3; i++) model_sample(i, longint'(d), e);
      end
      ep_at[e] = epoch;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic monitor_inst(input int i, input int c);
    bit   exp_v, exp_f;
    exp_t e;
    exp_f = first_ev[i][ep_at[c]] <= c;
    if (clr_at[c]) begin
      while (sb_q[i].size() > 0 && sb_q[i][0].t < c) void'(sb_q[i].pop_front());
      last_d[i] = 0;
      chk("clr_valid", i, c, longint'(dut_v[i]), 0);
      chk("clr_data", i, c, dut_d[i], 0);
      chk("clr_ovf", i, c, longint'(dut_f[i]), 0);
    end else begin
      exp_v = sb_q[i].size() > 0 && sb_q[i][0].out_c == c;
      chk("valid", i, c, longint'(dut_v[i]), longint'(exp_v));
      if (exp_v) begin
        e = sb_q[i].pop_front();
        last_d[i] = e.data;
      end
      chk("data", i, c, dut_d[i], last_d[i]);
      chk("ovf", i, c, longint'(dut_f[i]), longint'(exp_f));
    end
  endtask

  always @(negedge i_clk) begin
    if (!done && cyc > 0 && cyc < NCYC)
      for (int i = 0; i < 3; i++) monitor_inst(i, cyc);
  end

  initial begin
    int r;
    for (int i = 0; i < 3; i++) begin
      last_d[i] = 0;
      for (int m = 1; m <= 5; m++) s[i][m] = 0;
      for (int k = 0; k < NEP; k++) first_ev[i][k] = BIG;
    end

    // reset held with a live input, then one quiet cycle
    repeat (3) step(1'b1, 1'b0, 1'b1, 5);
    idle(1);
    // step response
    repeat (8) step(1'b0, 1'b0, 1'b1, 1);
    idle(4);
    // gapped stream 1,0,1
    step(1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 2);
    step(1'b0, 1'b0, 1'b0, 2);
    step(1'b0, 1'b0, 1'b1, 2);
    idle(4);
    // overflow with +7
    step(1'b0, 1'b1, 1'b0, 0);
    repeat (8) step(1'b0, 1'b0, 1'b1, 7);
    idle(4);
    // clear colliding with a valid sample mid-stream
    step(1'b0, 1'b1, 1'b0, 0);
    repeat (3) step(1'b0, 1'b0, 1'b1, 3);
    step(1'b0, 1'b1, 1'b1, 3);
    idle(6);
    // constant -1
    step(1'b0, 1'b1, 1'b0, 0);
    repeat (6) step(1'b0, 1'b0, 1'b1, -1);
    idle(4);
    // random traffic with occasional reset/clear
    for (int k = 0; k < 1500; k++) begin
      r = int'($urandom_range(0, 127));
      step(r == 0, (r == 1) || (r == 2), $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 15)) - 8);
    end
    idle(8);
    done = 1'b1;
    for (int i = 0; i < 3; i++) chk("drain", i, cyc, longint'(sb_q[i].size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
